// File: rtl/mem_requester_pkg.sv
// Shared definitions for the memory requester and the 128x8 memory block.
package mem_requester_pkg;

    localparam int unsigned MEM_ADDR_W = 7;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } req_state_t;

    // Bits needed to count 0..limit inclusive (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_requester.sv
// Initiator for the en/read/write/ready memory handshake: one load/store at a
// time, address/mode set up a cycle before enable, bounded wait for ready,
// return-to-zero on ready before the single-cycle response.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_input_data,
    input  logic [DATA_W-1:0] mem_output_data,
    input  logic              mem_ready
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    req_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Saturating increment of the ACCESS wait counter.
    always_comb begin
        cnt_next = cnt;
        if (cnt != '1) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Request sequencer; the address/data/mode output registers double as the
    // latched copy of the accepted request, so no separate capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_en         <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_input_data <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready      <= 1'b0;
                        mem_address    <= req_addr;
                        mem_input_data <= req_wdata;
                        mem_write      <= req_write;
                        mem_read       <= !req_write;
                        state          <= ST_SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    mem_en <= 1'b1;
                    cnt    <= '0;
                    state  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    cnt <= cnt_next;
                    if (mem_ready) begin
                        mem_en   <= 1'b0;
                        resp_err <= 1'b0;
                        if (!mem_write) begin
                            resp_rdata <= mem_output_data;
                        end
                        state <= ST_RELEASE;
                    end else if (cnt_next == CNT_LIMIT) begin
                        mem_en   <= 1'b0;
                        resp_err <= 1'b1;
                        state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!mem_ready) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
